mem_request_scheduler: RTL and testbench

Scheduler stage directly upstream of the page-access-counter request mux. It buffers memory requests from two producers in per-port FIFOs and arbitrates between them round-robin. It presents both FIFO heads plus a `sel` control to `mem_request_arbiter`, and exposes a valid/ready handshake towards the downstream consumer of the muxed request. Per-port served counters support bandwidth debug.

---
 rtl/ctrl_signal_types.sv | 12 +
 rtl/mem_request_fifo.sv | 62 ++++++
 rtl/mem_request_scheduler.sv | 102 ++++++++++
 tb/tb_mem_request_scheduler.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/ctrl_signal_types.sv
// Shared request/control types used by the memory request path.
package ctrl_signal_types;

  typedef struct packed {
    logic [15:0] addr;
    logic        we;
    logic [7:0]  id;
  } mem_request_t;

  typedef enum logic {PORT1 = 1'b0, PORT2 = 1'b1} req_port_t;

endpackage

// File: rtl/mem_request_fifo.sv
// Per-port request FIFO: power-of-two depth, no full- or empty-bypass,
// head driven straight from storage.
module mem_request_fifo
  import ctrl_signal_types::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  mem_request_t push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output mem_request_t head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  mem_request_t     mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == FULL_CNT);
  assign empty     = (count_r == '0);
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign head      = mem_r[rd_ptr_r];

  // Pointer and occupancy state; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage is not cleared; reset only discards it through the pointers.
  always_ff @(posedge clk) begin
    if (!reset && do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

endmodule

// File: rtl/mem_request_scheduler.sv
// Two-port request scheduler: per-port FIFOs, round-robin grant that holds
// steady under backpressure, and saturating per-port served counters.
module mem_request_scheduler
  import ctrl_signal_types::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in1_valid,
  input  mem_request_t     in1_req,
  output logic             in1_ready,
  input  logic             in2_valid,
  input  mem_request_t     in2_req,
  output logic             in2_ready,
  output mem_request_t     head1,
  output mem_request_t     head2,
  output req_port_t        sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] served1_cnt,
  output logic [CNT_W-1:0] served2_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic      full1_s, empty1_s, full2_s, empty2_s;
  logic      push1_s, push2_s, pop1_s, pop2_s, hs_s;
  logic      lock_r;
  req_port_t grant_s, sel_q_r, last_served_r;

  assign in1_ready = !full1_s;
  assign in2_ready = !full2_s;
  assign push1_s   = in1_valid && !full1_s;
  assign push2_s   = in2_valid && !full2_s;
  assign out_valid = !empty1_s || !empty2_s;
  assign hs_s      = out_valid && out_ready;
  assign pop1_s    = hs_s && (sel == PORT1);
  assign pop2_s    = hs_s && (sel == PORT2);

  mem_request_fifo #(.DEPTH(DEPTH)) u_fifo1 (
    .clk(clk), .reset(reset), .push(push1_s), .push_data(in1_req),
    .pop(pop1_s), .full(full1_s), .empty(empty1_s), .head(head1)
  );

  mem_request_fifo #(.DEPTH(DEPTH)) u_fifo2 (
    .clk(clk), .reset(reset), .push(push2_s), .push_data(in2_req),
    .pop(pop2_s), .full(full2_s), .empty(empty2_s), .head(head2)
  );

  // Unlocked round-robin choice; both-empty falls back to port 1.
  always_comb begin
    grant_s = PORT1;
    case ({!empty1_s, !empty2_s})
      2'b10:   grant_s = PORT1;
      2'b01:   grant_s = PORT2;
      2'b11:   grant_s = (last_served_r == PORT1) ? PORT2 : PORT1;
      default: grant_s = PORT1;
    endcase
  end

  // A stalled request stays presented until it is accepted.
  always_comb begin
    if (lock_r) begin
      sel = sel_q_r;
    end else begin
      sel = grant_s;
    end
  end

  // Arbitration history and backpressure lock.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_r        <= 1'b0;
      sel_q_r       <= PORT1;
      last_served_r <= PORT2;
    end else if (hs_s) begin
      lock_r        <= 1'b0;
      last_served_r <= sel;
    end else if (out_valid) begin
      lock_r  <= 1'b1;
      sel_q_r <= sel;
    end
  end

  // Saturating handshake counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      served1_cnt <= '0;
      served2_cnt <= '0;
    end else begin
      if (pop1_s && (served1_cnt != CNT_MAX)) begin
        served1_cnt <= served1_cnt + 1'b1;
      end
      if (pop2_s && (served2_cnt != CNT_MAX)) begin
        served2_cnt <= served2_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_request_scheduler.sv
// Randomized bench for mem_request_scheduler against a queue-based reference model.
module tb_mem_request_scheduler;
  import ctrl_signal_types::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset, in1_valid, in2_valid, out_ready;
  mem_request_t     in1_req, in2_req, head1, head2;
  logic             in1_ready, in2_ready, out_valid;
  req_port_t        sel;
  logic [CNT_W-1:0] served1_cnt, served2_cnt;

  mem_request_scheduler #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in1_valid(in1_valid), .in1_req(in1_req), .in1_ready(in1_ready),
    .in2_valid(in2_valid), .in2_req(in2_req), .in2_ready(in2_ready),
    .head1(head1), .head2(head2), .sel(sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .served1_cnt(served1_cnt), .served2_cnt(served2_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: queues plus arbitration history.
  mem_request_t q1[$], q2[$];
  int m_last = 1, m_lock = 0, m_lsel = 0, m_c1 = 0, m_c2 = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int model_sel();
    if (m_lock != 0) return m_lsel;
    if (q1.size() > 0 && q2.size() > 0) return 1 - m_last;
    if (q2.size() > 0) return 1;
    return 0;
  endfunction

  function automatic mem_request_t rand_req();
    mem_request_t r;
    logic [31:0] x;
    x = $urandom;
    r.addr = x[15:0];
    r.we   = x[16];
    r.id   = x[24:17];
    return r;
  endfunction

  task automatic model_reset();
    q1.delete();
    q2.delete();
    m_last = 1; m_lock = 0; m_lsel = 0; m_c1 = 0; m_c2 = 0;
  endtask

  task automatic check_outputs();
    check_val("in1_ready", in1_ready, (q1.size() < DEPTH) ? 1 : 0);
    check_val("in2_ready", in2_ready, (q2.size() < DEPTH) ? 1 : 0);
    check_val("out_valid", out_valid, (q1.size() > 0 || q2.size() > 0) ? 1 : 0);
    check_val("sel", sel, model_sel());
    if (q1.size() > 0) check_val("head1", head1, q1[0]);
    if (q2.size() > 0) check_val("head2", head2, q2[0]);
    check_val("served1_cnt", served1_cnt, m_c1);
    check_val("served2_cnt", served2_cnt, m_c2);
  endtask

  // One clock: drive at negedge, advance model, check just after the edge.
  task automatic cycle(input logic rst, input logic v1, input logic v2, input logic ordy);
    int s;
    bit ov, p1, p2;
    @(negedge clk);
    reset = rst; in1_valid = v1; in2_valid = v2; out_ready = ordy;
    in1_req = rand_req(); in2_req = rand_req();
    if (rst) begin
      model_reset();
    end else begin
      s  = model_sel();
      ov = (q1.size() > 0) || (q2.size() > 0);
      p1 = v1 && (q1.size() < DEPTH);
      p2 = v2 && (q2.size() < DEPTH);
      if (ov && ordy) begin
        if (s == 0) begin
          void'(q1.pop_front());
          if (m_c1 < CNT_MAX) m_c1++;
        end else begin
          void'(q2.pop_front());
          if (m_c2 < CNT_MAX) m_c2++;
        end
        m_last = s;
        m_lock = 0;
      end else if (ov) begin
        m_lock = 1;
        m_lsel = s;
      end
      if (p1) q1.push_back(in1_req);
      if (p2) q2.push_back(in2_req);
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    reset = 1'b1; in1_valid = 1'b0; in2_valid = 1'b0; out_ready = 1'b0;
    in1_req = '0; in2_req = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_outputs();

    // Port 1 only, two requests, consumer always ready.
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check_val("two_served", served1_cnt, 2);

    // Preload three each, then drain: grants alternate starting at port 1.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (6) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check_val("rr_cnt1", served1_cnt, 3);
    check_val("rr_cnt2", served2_cnt, 3);

    // Backpressure while port 2 keeps pushing.
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (5) cycle(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (6) cycle(1'b0, 1'b0, 1'b0, 1'b1);

    // Fill port 1, refuse the fifth, then free one slot.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (4) cycle(1'b0, 1'b1, 1'b0, 1'b0);
    check_val("full_ready", in1_ready, 0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check_val("freed_ready", in1_ready, 1);
    repeat (10) cycle(1'b0, 1'b1, 1'b0, 1'b1);

    // Reset with entries queued and the lock held.
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_sel", sel, 0);
    check_val("rst_cnt1", served1_cnt, 0);

    // Counter saturation over 20 port-1 handshakes.
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    repeat (20) cycle(1'b0, 1'b1, 1'b0, 1'b1);
    check_val("sat_cnt1", served1_cnt, CNT_MAX);

    // Random traffic with occasional reset.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 79) == 0), $urandom_range(0, 1) == 1,
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
